// File: rtl/mult_mat_seq_if.sv
// rtl/mult_mat_seq_if.sv - handshake and matrix bus for the sequential matrix multiplier
interface mult_mat_seq_if #(
  parameter int M    = 2,
  parameter int K    = 3,
  parameter int N    = 3,
  parameter int W    = 1,
  parameter int MODE = 0
);
  localparam int RW = (MODE == 0) ? W : 2 * W + $clog2(K);

  logic                clk_enable;
  logic                start;
  logic [M*K*W-1:0]    matriz_A;
  logic [K*N*W-1:0]    matriz_B;
  logic [M*N*RW-1:0]   matriz_resultado;
  logic                busy;
  logic                done;

  modport master (
    output clk_enable, start, matriz_A, matriz_B,
    input  matriz_resultado, busy, done
  );

  modport slave (
    input  clk_enable, start, matriz_A, matriz_B,
    output matriz_resultado, busy, done
  );
endinterface

// File: rtl/mult_mat_seq.sv
// rtl/mult_mat_seq.sv - sequential R = A x B with one MAC per enabled clock
// Loop order is k innermost, then j, then i; results publish all at once on the last MAC.
module mult_mat_seq #(
  parameter int M    = 2,
  parameter int K    = 3,
  parameter int N    = 3,
  parameter int W    = 1,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_mat_seq_if.slave bus
);
  localparam int RW = (MODE == 0) ? W : 2 * W + $clog2(K);
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(M - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [M*K*W-1:0]    a_q;
  logic [K*N*W-1:0]    b_q;
  logic [IW-1:0]       i_q;
  logic [JW-1:0]       j_q;
  logic [KW-1:0]       k_q;
  logic [RW-1:0]       acc_q;
  logic [M*N*RW-1:0]   shadow_q;
  logic [M*N*RW-1:0]   res_q;
  logic                busy_q;
  logic                done_q;

  logic                accept;
  logic                mac_en;
  logic                k_last;
  logic                j_last;
  logic                i_last;
  logic                last_mac;
  logic                busy_next;
  logic                done_next;
  logic [W-1:0]        a_el;
  logic [W-1:0]        b_el;
  logic [RW-1:0]       prod;
  logic [RW-1:0]       acc_base;
  logic [RW-1:0]       acc_next;
  logic [M*N*RW-1:0]   shadow_next;

  assign k_last   = (k_q == K_LAST);
  assign j_last   = (j_q == J_LAST);
  assign i_last   = (i_q == I_LAST);
  assign last_mac = i_last && j_last && k_last;

  always_comb begin
    a_el = a_q[(int'(i_q) * K + int'(k_q)) * W +: W];
    b_el = b_q[(int'(k_q) * N + int'(j_q)) * W +: W];
  end

  // A fresh element starts from zero, so the accumulator needs no clearing between elements
  assign acc_base = (k_q == '0) ? '0 : acc_q;

  generate
    if (MODE == 0) begin : g_gf2
      assign prod     = RW'(a_el & b_el);
      assign acc_next = acc_base ^ prod;
    end else begin : g_int
      logic [2*W-1:0] mul;
      assign mul      = {{W{1'b0}}, a_el} * {{W{1'b0}}, b_el};
      assign prod     = RW'(mul);
      assign acc_next = acc_base + prod;
    end
  endgenerate

  always_comb begin
    shadow_next = shadow_q;
    if (k_last) begin
      shadow_next[(int'(i_q) * N + int'(j_q)) * RW +: RW] = acc_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_next  = busy_q;
    done_next  = 1'b0;
    accept     = 1'b0;
    mac_en     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          busy_next  = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        mac_en = 1'b1;
        if (last_mac) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (bus.clk_enable) begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.clk_enable) begin
      busy_q <= busy_next;
      done_q <= done_next;
      if (accept) begin
        a_q   <= bus.matriz_A;
        b_q   <= bus.matriz_B;
        i_q   <= '0;
        j_q   <= '0;
        k_q   <= '0;
        acc_q <= '0;
      end else if (mac_en) begin
        acc_q    <= acc_next;
        shadow_q <= shadow_next;
        if (k_last) begin
          k_q <= '0;
          if (j_last) begin
            j_q <= '0;
            i_q <= i_last ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end else begin
          k_q <= k_q + 1'b1;
        end
        // The visible result only ever changes here, so it holds the previous run throughout CALC
        if (last_mac) begin
          res_q <= shadow_next;
        end
      end
    end
  end

  assign bus.matriz_resultado = res_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
endmodule

// File: tb/tb_mult_mat_seq.sv
// tb/tb_mult_mat_seq.sv - scoreboard bench for mult_mat_seq (GF(2) defaults and 2x2 integer mode)
module tb_mult_mat_seq;
  typedef struct {
    logic [35:0] res;
    int          acc;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst0_n;
  logic rst1_n;
  int   cycle;
  int   checks;
  int   errors;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [35:0] held0, held1;
  int          busy_cnt0, busy_cnt1;
  logic        done0_prev, done1_prev;

  mult_mat_seq_if #(.M(2), .K(3), .N(3), .W(1), .MODE(0)) b0 ();
  mult_mat_seq_if #(.M(2), .K(2), .N(2), .W(4), .MODE(1)) b1 ();

  mult_mat_seq #(.M(2), .K(3), .N(3), .W(1), .MODE(0)) u0 (.clk(clk), .rst_n(rst0_n), .bus(b0));
  mult_mat_seq #(.M(2), .K(2), .N(2), .W(4), .MODE(1)) u1 (.clk(clk), .rst_n(rst1_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: R[r][c] = XOR over t of (A[r][t] AND B[t][c])
  function automatic logic [5:0] ref0(input logic [5:0] a, input logic [8:0] b);
    logic [5:0] res;
    res = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        logic s;
        s = 1'b0;
        for (int t = 0; t < 3; t++) s = s ^ (a[r*3+t] & b[t*3+c]);
        res[r*3+c] = s;
      end
    end
    return res;
  endfunction

  // Reference: ordinary integer matrix product on 4-bit elements, 9-bit results
  function automatic logic [35:0] ref1(input logic [15:0] a, input logic [15:0] b);
    logic [35:0] res;
    res = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        int s;
        s = 0;
        for (int t = 0; t < 2; t++) s += int'(a[(r*2+t)*4 +: 4]) * int'(b[(t*2+c)*4 +: 4]);
        res[(r*2+c)*9 +: 9] = 9'(s);
      end
    end
    return res;
  endfunction

  always @(negedge clk) begin
    if (rst0_n) begin
      if (b0.done && !done0_prev) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL u0 unexpected done: got done=1 required no run pending (cycle %0d)", cycle);
        end else begin
          exp_t e;
          e = q0.pop_front();
          chk("u0 result", b0.matriz_resultado, e.res);
          chk("u0 done cycle", cycle, e.cyc);
          chk("u0 busy cycles", busy_cnt0, e.cyc - e.acc);
          chk("u0 busy low at done", b0.busy, 1'b0);
          held0 = e.res;
        end
        busy_cnt0 = 0;
      end else begin
        chk("u0 result hold", b0.matriz_resultado, held0);
      end
      if (b0.busy) busy_cnt0++;
    end
    done0_prev = b0.done;
  end

  always @(negedge clk) begin
    if (rst1_n) begin
      if (b1.done && !done1_prev) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL u1 unexpected done: got done=1 required no run pending (cycle %0d)", cycle);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("u1 result", b1.matriz_resultado, e.res);
          chk("u1 done cycle", cycle, e.cyc);
          chk("u1 busy cycles", busy_cnt1, e.cyc - e.acc);
          chk("u1 busy low at done", b1.busy, 1'b0);
          held1 = e.res;
        end
        busy_cnt1 = 0;
      end else begin
        chk("u1 result hold", b1.matriz_resultado, held1);
      end
      if (b1.busy) busy_cnt1++;
    end
    done1_prev = b1.done;
  end

  task automatic go0(input logic [5:0] a, input logic [8:0] b, input int extra);
    @(negedge clk);
    b0.matriz_A   = a;
    b0.matriz_B   = b;
    b0.start      = 1'b1;
    b0.clk_enable = 1'b1;
    q0.push_back('{res: 36'(ref0(a, b)), acc: cycle + 1, cyc: cycle + 1 + 18 + extra});
    @(negedge clk);
    b0.start = 1'b0;
  endtask

  task automatic go1(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    b1.matriz_A   = a;
    b1.matriz_B   = b;
    b1.start      = 1'b1;
    b1.clk_enable = 1'b1;
    q1.push_back('{res: ref1(a, b), acc: cycle + 1, cyc: cycle + 1 + 8});
    @(negedge clk);
    b1.start = 1'b0;
  endtask

  task automatic wait0(input int budget);
    int n;
    n = 0;
    while (q0.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (q0.size() != 0) begin
      checks++; errors++;
      $display("FAIL u0 timeout: %0d runs still pending after %0d cycles, required 0", q0.size(), budget);
      q0.delete();
    end
  endtask

  task automatic wait1(input int budget);
    int n;
    n = 0;
    while (q1.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (q1.size() != 0) begin
      checks++; errors++;
      $display("FAIL u1 timeout: %0d runs still pending after %0d cycles, required 0", q1.size(), budget);
      q1.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    held0 = '0; held1 = '0;
    busy_cnt0 = 0; busy_cnt1 = 0;
    done0_prev = 1'b0; done1_prev = 1'b0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    b0.clk_enable = 1'b1; b0.start = 1'b0; b0.matriz_A = '0; b0.matriz_B = '0;
    b1.clk_enable = 1'b1; b1.start = 1'b0; b1.matriz_A = '0; b1.matriz_B = '0;

    repeat (3) @(negedge clk);
    chk("u0 reset busy", b0.busy, 1'b0);
    chk("u0 reset done", b0.done, 1'b0);
    chk("u0 reset result", b0.matriz_resultado, 36'h0);
    chk("u1 reset result", b1.matriz_resultado, 36'h0);
    rst0_n = 1'b1; rst1_n = 1'b1;

    // Directed GF(2) vectors
    go0(6'b111111, 9'b111111111, 0);
    wait0(60);
    go0(6'b010001, 9'b101110011, 0);
    wait0(60);

    // Pending done survives a disabled stretch and clears on the next enabled edge
    b0.clk_enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("u0 done held while disabled", b0.done, 1'b1);
    end
    b0.clk_enable = 1'b1;
    @(negedge clk);
    chk("u0 done cleared", b0.done, 1'b0);

    // Five disabled cycles mid-run plus a start pulse while busy
    go0(6'b101101, 9'b011010110, 5);
    repeat (5) @(negedge clk);
    b0.clk_enable = 1'b0;
    repeat (5) @(negedge clk);
    b0.clk_enable = 1'b1;
    b0.start      = 1'b1;
    b0.matriz_A   = 6'b000000;
    @(negedge clk);
    b0.start = 1'b0;
    wait0(80);
    repeat (25) @(negedge clk);

    // Reset after 7 MACs aborts the run
    go0(6'b111111, 9'b111111111, 0);
    repeat (7) @(negedge clk);
    #2 rst0_n = 1'b0;
    #1;
    chk("u0 abort busy", b0.busy, 1'b0);
    chk("u0 abort done", b0.done, 1'b0);
    chk("u0 abort result", b0.matriz_resultado, 36'h0);
    q0.delete();
    held0 = '0;
    busy_cnt0 = 0;
    #1 rst0_n = 1'b1;
    go0(6'b110011, 9'b100010001, 0);
    wait0(60);

    // Start held across two runs; second inputs change after the first is latched
    @(negedge clk);
    b0.matriz_A = 6'b011110;
    b0.matriz_B = 9'b110101011;
    b0.start    = 1'b1;
    q0.push_back('{res: 36'(ref0(6'b011110, 9'b110101011)), acc: cycle + 1, cyc: cycle + 19});
    q0.push_back('{res: 36'(ref0(6'b100111, 9'b001111100)), acc: cycle + 20, cyc: cycle + 38});
    repeat (2) @(negedge clk);
    b0.matriz_A = 6'b100111;
    b0.matriz_B = 9'b001111100;
    n = 0;
    while (q0.size() > 1 && n < 60) begin @(negedge clk); #1; n++; end
    n = 0;
    while (!b0.busy && n < 5) begin @(negedge clk); n++; end
    b0.start = 1'b0;
    wait0(60);

    // Randomized GF(2) runs
    repeat (12) begin
      go0(6'($urandom), 9'($urandom), 0);
      wait0(60);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Integer mode: directed then random
    go1(16'h4321, 16'h8765);
    wait1(30);
    go1(16'hFFFF, 16'hFFFF);
    wait1(30);
    repeat (8) begin
      go1(16'($urandom), 16'($urandom));
      wait1(30);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
